reg_value_1: RTL and testbench

REG_VALUE_1 -- requirements
Module: reg_value1

---
 rtl/reg_value_1.sv | 78 +++++++
 tb/tb_reg_value_1.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_value_1.sv
`default_nettype none
// ============================================================================
//  Module      : reg_value_1
//  Description : Single-source operand forwarding mux. Resolves the value of
//                one source register. It takes either the stale register-file
//                read or the result of the in-flight first-priority producer.
//                A saturating 16-bit counter records how many clock edges saw
//                a forwarding hit.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_value_1 #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] ReadRegister1,
  input  logic [DATA_W-1:0]     RegisterData1,
  input  logic [REG_ADDR_W-1:0] WriteRegister1stPri1,
  input  logic [DATA_W-1:0]     WriteData1stPri1,
  input  logic                  Valid1stPri1,
  input  logic                  comment,
  output logic [DATA_W-1:0]     Output1,
  output logic                  Forwarded1,
  output logic [CNT_W-1:0]      HitCount
);

  localparam logic [REG_ADDR_W-1:0] C_REG_ZERO = '0;
  localparam logic [CNT_W-1:0]      C_CNT_MAX  = '1;

  logic                  w_addr_match;
  logic                  w_src_nonzero;
  logic                  w_forward;
  logic [DATA_W-1:0]     w_value;
  logic [CNT_W-1:0]      r_hit_count;

  // Forwarding decision: full-width address compare, register 0 never forwarded
  always_comb begin
    w_addr_match  = (WriteRegister1stPri1 == ReadRegister1);
    w_src_nonzero = (ReadRegister1 != C_REG_ZERO);
    w_forward     = Valid1stPri1 & w_addr_match & w_src_nonzero;
  end

  // Operand select; data passes through untouched, independent of clock/reset
  always_comb begin
    w_value = RegisterData1;
    if (w_forward) begin
      w_value = WriteData1stPri1;
    end
  end

  assign Output1    = w_value;
  assign Forwarded1 = w_forward;

  // Saturating hit counter, cleared asynchronously while RESET is high
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hit_count <= '0;
    end else if (w_forward && (r_hit_count != C_CNT_MAX)) begin
      r_hit_count <= r_hit_count + 1'b1;
    end
  end

  assign HitCount = r_hit_count;

`ifndef SYNTHESIS
  // Debug trace of the resolved operand on each edge when enabled
  always @(posedge CLK) begin
    if (comment) begin
      $display("reg_value_1: ReadRegister1=%0d Forwarded1=%0b Output1=%08h",
               ReadRegister1, w_forward, w_value);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_value_1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_value_1
//  Description : Directed self-checking bench for reg_value_1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_value_1;

  logic        CLK;
  logic        RESET;
  logic [4:0]  ReadRegister1;
  logic [31:0] RegisterData1;
  logic [4:0]  WriteRegister1stPri1;
  logic [31:0] WriteData1stPri1;
  logic        Valid1stPri1;
  logic        comment;
  logic [31:0] Output1;
  logic        Forwarded1;
  logic [15:0] HitCount;

  int total;
  int bad;

  reg_value_1 dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .ReadRegister1        (ReadRegister1),
    .RegisterData1        (RegisterData1),
    .WriteRegister1stPri1 (WriteRegister1stPri1),
    .WriteData1stPri1     (WriteData1stPri1),
    .Valid1stPri1         (Valid1stPri1),
    .comment              (comment),
    .Output1              (Output1),
    .Forwarded1           (Forwarded1),
    .HitCount             (HitCount)
  );

  // 10 ns clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drive(input logic [4:0] rr, input logic [31:0] rd,
                       input logic [4:0] wr, input logic [31:0] wd,
                       input logic v);
    ReadRegister1        = rr;
    RegisterData1        = rd;
    WriteRegister1stPri1 = wr;
    WriteData1stPri1     = wd;
    Valid1stPri1         = v;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    drive(5'd5, 32'h1111_1111, 5'd5, 32'hDEAD_BEEF, 1'b1);
    RESET = 1'b1;
    #1;
    total++;
    if (HitCount !== 16'h0000) begin
      bad++;
      $display("FAIL reset_count: got %h want %h", HitCount, 16'h0000);
    end
    @(posedge CLK);
    #1;
    total++;
    if (HitCount !== 16'h0000) begin
      bad++;
      $display("FAIL reset_hold_count: got %h want %h", HitCount, 16'h0000);
    end
    total++;
    if (Output1 !== 32'hDEAD_BEEF || Forwarded1 !== 1'b1) begin
      bad++;
      $display("FAIL reset_fwd: got %h/%b want %h/1", Output1, Forwarded1, 32'hDEAD_BEEF);
    end
    @(negedge CLK);
    RESET = 1'b0;
    Valid1stPri1 = 1'b0;
  endtask

  task automatic test_comb_vectors();
    // {rr, rd, wr, wd, v, expected out, expected fwd}
    logic [4:0]  rr [8];
    logic [31:0] rd [8];
    logic [4:0]  wr [8];
    logic [31:0] wd [8];
    logic        v  [8];
    logic [31:0] eo [8];
    logic        ef [8];
    // hit
    rr[0]=5'd5;  rd[0]=32'h1111_1111; wr[0]=5'd5;  wd[0]=32'hDEAD_BEEF; v[0]=1; eo[0]=32'hDEAD_BEEF; ef[0]=1;
    // producer not valid
    rr[1]=5'd5;  rd[1]=32'h1111_1111; wr[1]=5'd5;  wd[1]=32'hDEAD_BEEF; v[1]=0; eo[1]=32'h1111_1111; ef[1]=0;
    // register mismatch
    rr[2]=5'd5;  rd[2]=32'h2222_3333; wr[2]=5'd6;  wd[2]=32'hDEAD_BEEF; v[2]=1; eo[2]=32'h2222_3333; ef[2]=0;
    // register zero never forwarded
    rr[3]=5'd0;  rd[3]=32'h0000_0000; wr[3]=5'd0;  wd[3]=32'hFFFF_FFFF; v[3]=1; eo[3]=32'h0000_0000; ef[3]=0;
    // top address bit differs only (5 vs 21)
    rr[4]=5'd5;  rd[4]=32'h0000_0044; wr[4]=5'd21; wd[4]=32'h5555_AAAA; v[4]=1; eo[4]=32'h0000_0044; ef[4]=0;
    // register 31, MSB-set data passes without masking
    rr[5]=5'd31; rd[5]=32'h0000_0001; wr[5]=5'd31; wd[5]=32'h8000_0000; v[5]=1; eo[5]=32'h8000_0000; ef[5]=1;
    // register 16 vs 0: only bit 4 differs
    rr[6]=5'd16; rd[6]=32'hCAFE_F00D; wr[6]=5'd0;  wd[6]=32'h1234_5678; v[6]=1; eo[6]=32'hCAFE_F00D; ef[6]=0;
    // register 1 hit with negative-looking byte data
    rr[7]=5'd1;  rd[7]=32'h7FFF_FFFF; wr[7]=5'd1;  wd[7]=32'h0000_00FF; v[7]=1; eo[7]=32'h0000_00FF; ef[7]=1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      drive(rr[i], rd[i], wr[i], wd[i], v[i]);
      #1;
      total++;
      if (Output1 !== eo[i] || Forwarded1 !== ef[i]) begin
        bad++;
        $display("FAIL comb_vec%0d: got %h/%b want %h/%b", i, Output1, Forwarded1, eo[i], ef[i]);
      end
    end
    @(negedge CLK);
    Valid1stPri1 = 1'b0;
  endtask

  task automatic test_comb_follow();
    @(negedge CLK);
    drive(5'd9, 32'hAAAA_0000, 5'd9, 32'h0000_0001, 1'b1);
    #1;
    WriteData1stPri1 = 32'h0000_0002;
    #1;
    total++;
    if (Output1 !== 32'h0000_0002) begin
      bad++;
      $display("FAIL follow_data: got %h want %h", Output1, 32'h0000_0002);
    end
    WriteRegister1stPri1 = 5'd8;
    #1;
    total++;
    if (Output1 !== 32'hAAAA_0000 || Forwarded1 !== 1'b0) begin
      bad++;
      $display("FAIL follow_reg: got %h/%b want %h/0", Output1, Forwarded1, 32'hAAAA_0000);
    end
    Valid1stPri1 = 1'b0;
  endtask

  task automatic test_counter_reset();
    pulse_reset();
    @(negedge CLK);
    comment = 1'b1;
    drive(5'd5, 32'h1111_1111, 5'd5, 32'hDEAD_BEEF, 1'b1);
    repeat (3) @(posedge CLK);
    #1;
    comment = 1'b0;
    total++;
    if (HitCount !== 16'd3) begin
      bad++;
      $display("FAIL count3: got %0d want 3", HitCount);
    end
    // miss cycles hold the count
    @(negedge CLK);
    Valid1stPri1 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (HitCount !== 16'd3) begin
      bad++;
      $display("FAIL count_hold: got %0d want 3", HitCount);
    end
    @(negedge CLK);
    Valid1stPri1 = 1'b1;
    #1;
    RESET = 1'b1;
    #1;
    total++;
    if (HitCount !== 16'd0) begin
      bad++;
      $display("FAIL async_clear: got %0d want 0", HitCount);
    end
    total++;
    if (Output1 !== 32'hDEAD_BEEF || Forwarded1 !== 1'b1) begin
      bad++;
      $display("FAIL fwd_in_reset: got %h/%b want %h/1", Output1, Forwarded1, 32'hDEAD_BEEF);
    end
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    total++;
    if (HitCount !== 16'd1) begin
      bad++;
      $display("FAIL resume: got %0d want 1", HitCount);
    end
    @(negedge CLK);
    Valid1stPri1 = 1'b0;
  endtask

  task automatic test_saturation();
    pulse_reset();
    @(negedge CLK);
    drive(5'd7, 32'h0, 5'd7, 32'h1357_9BDF, 1'b1);
    repeat (65534) @(posedge CLK);
    #1;
    total++;
    if (HitCount !== 16'hFFFE) begin
      bad++;
      $display("FAIL sat_pre: got %h want %h", HitCount, 16'hFFFE);
    end
    @(posedge CLK);
    #1;
    total++;
    if (HitCount !== 16'hFFFF) begin
      bad++;
      $display("FAIL sat_reach: got %h want %h", HitCount, 16'hFFFF);
    end
    repeat (5) @(posedge CLK);
    #1;
    total++;
    if (HitCount !== 16'hFFFF) begin
      bad++;
      $display("FAIL sat_nowrap: got %h want %h", HitCount, 16'hFFFF);
    end
    @(negedge CLK);
    Valid1stPri1 = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    RESET   = 1'b0;
    comment = 1'b0;
    drive(5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    test_reset();
    test_comb_vectors();
    test_comb_follow();
    test_counter_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
